// File: rtl/mul_exec_stage_if.sv
// Issue/writeback bundle for the multiply execute stage.
// master = issue + writeback side, slave = the stage itself.
interface mul_exec_stage_if #(
    parameter int N     = 16,
    parameter int TAG_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_data, out_tag, busy
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
        output in_ready, out_valid, out_data, out_tag, busy
    );
endinterface

// File: rtl/mul_exec_stage.sv
// Three-stage multiply execute: sign condition, unsigned product,
// sign fix + half select. Bubble-collapsing valid/ready with flush.
module mul_exec_stage #(
    parameter int N     = 16,
    parameter int TAG_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    mul_exec_stage_if.slave io
);
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    logic             s1_v, s2_v, s3_v;
    logic [1:0]       s1_op, s2_op;
    logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag;
    logic [N-1:0]     s1_a, s1_b;
    logic             s1_neg, s2_neg;
    logic [2*N-1:0]   s2_p;
    logic [N-1:0]     s3_data;

    logic s3_load, s2_load, s1_move, s2_move, in_fire;

    assign s3_load  = !s3_v || io.out_ready;
    assign s2_move  = s2_v && s3_load;
    assign s2_load  = !s2_v || s2_move;
    assign s1_move  = s1_v && s2_load;
    assign io.in_ready = !io.flush && (!s1_v || s1_move);
    assign in_fire  = io.in_valid && io.in_ready;

    assign io.out_valid = s3_v;
    assign io.out_data  = s3_data;
    assign io.out_tag   = s3_tag;
    assign io.busy      = s1_v || s2_v || s3_v;

    logic [N-1:0] a_abs, b_abs, c_a, c_b;
    logic         c_neg;

    // Operand conditioning: magnitudes and predicted result sign
    always_comb begin
        a_abs = io.in_a[N-1] ? (~io.in_a + N'(1)) : io.in_a;
        b_abs = io.in_b[N-1] ? (~io.in_b + N'(1)) : io.in_b;
        c_a   = io.in_a;
        c_b   = io.in_b;
        c_neg = 1'b0;
        unique case (io.in_op)
            OP_MULH: begin
                c_a   = a_abs;
                c_b   = b_abs;
                c_neg = io.in_a[N-1] ^ io.in_b[N-1];
            end
            OP_MULHSU: begin
                c_a   = a_abs;
                c_neg = io.in_a[N-1];
            end
            default: ;
        endcase
    end

    logic [2*N-1:0] prod;
    logic [2*N-1:0] p_fix;
    logic [N-1:0]   res;

    // Unsigned array product of the conditioned magnitudes
    always_comb begin
        prod = {{N{1'b0}}, s1_a} * {{N{1'b0}}, s1_b};
    end

    // Sign restore on the full product, then pick the half
    always_comb begin
        p_fix = s2_neg ? (~s2_p + (2*N)'(1)) : s2_p;
        res   = (s2_op == OP_MUL) ? p_fix[N-1:0] : p_fix[2*N-1:N];
    end

    // Stage valid bits; flush kills everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
        end else if (io.flush) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
        end else begin
            if (s3_load) s3_v <= s2_v;
            if (s2_load) s2_v <= s1_v;
            if (!s1_v || s1_move) s1_v <= in_fire;
        end
    end

    // Stage payloads; each loads only when a valid op moves in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_op   <= '0;
            s1_tag  <= '0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_neg  <= 1'b0;
            s2_op   <= '0;
            s2_tag  <= '0;
            s2_p    <= '0;
            s2_neg  <= 1'b0;
            s3_tag  <= '0;
            s3_data <= '0;
        end else begin
            if (in_fire) begin
                s1_op  <= io.in_op;
                s1_tag <= io.in_tag;
                s1_a   <= c_a;
                s1_b   <= c_b;
                s1_neg <= c_neg;
            end
            if (s2_load && s1_v) begin
                s2_op  <= s1_op;
                s2_tag <= s1_tag;
                s2_p   <= prod;
                s2_neg <= s1_neg;
            end
            if (s3_load && s2_v) begin
                s3_tag  <= s2_tag;
                s3_data <= res;
            end
        end
    end
endmodule

// File: tb/tb_mul_exec_stage.sv
// Self-checking bench for mul_exec_stage: vector table, corner
// sequences, then randomized traffic against a scoreboard model.
module tb_mul_exec_stage;
    localparam int N = 16;
    localparam int TW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_exec_stage_if #(.N(N), .TAG_W(TW)) io ();

    mul_exec_stage #(.N(N), .TAG_W(TW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io(io.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [1:0] op,
                                           input logic [N-1:0] a,
                                           input logic [N-1:0] b);
        longint sa, sb, ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            2'b00: r = ua * ub;
            2'b01: r = sa * sb;
            2'b10: r = sa * ub;
            default: r = ua * ub;
        endcase
        return (op == 2'b00) ? r[15:0] : r[31:16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        io.in_valid = 1'b0;
        io.in_op = 2'b00;
        io.in_a = '0;
        io.in_b = '0;
        io.in_tag = '0;
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic [TW-1:0] tag;
        logic [N-1:0]  exp;
    } vec_t;

    vec_t vecs[7];

    typedef struct {
        logic [N-1:0]  d;
        logic [TW-1:0] t;
    } res_t;

    res_t q[$];
    logic [N-1:0]  held_d;
    logic [TW-1:0] held_t;
    logic          held;

    initial begin
        vecs[0] = '{2'b00, 16'h1234, 16'h0010, 3'd5, 16'h2340};
        vecs[1] = '{2'b01, 16'h8000, 16'h8000, 3'd1, 16'h4000};
        vecs[2] = '{2'b01, 16'hFFFF, 16'h0002, 3'd2, 16'hFFFF};
        vecs[3] = '{2'b11, 16'hFFFF, 16'hFFFF, 3'd3, 16'hFFFE};
        vecs[4] = '{2'b10, 16'hFFFF, 16'hFFFF, 3'd4, 16'hFFFF};
        vecs[5] = '{2'b00, 16'hFFFF, 16'hFFFF, 3'd6, 16'h0001};
        vecs[6] = '{2'b01, 16'h7FFF, 16'h8000, 3'd7, 16'hC000};

        idle();
        io.flush = 1'b0;
        io.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(io.out_valid), 0);
        chk("rst_busy", 32'(io.busy), 0);
        chk("rst_out_data", 32'(io.out_data), 0);
        chk("rst_out_tag", 32'(io.out_tag), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(io.in_ready), 1);

        // table: latency exactly 3 and value per op
        for (int i = 0; i < 7; i++) begin
            io.in_valid = 1'b1;
            io.in_op = vecs[i].op;
            io.in_a = vecs[i].a;
            io.in_b = vecs[i].b;
            io.in_tag = vecs[i].tag;
            chk($sformatf("vec%0d_in_ready", i), 32'(io.in_ready), 1);
            tick();
            idle();
            chk($sformatf("vec%0d_lat1", i), 32'(io.out_valid), 0);
            tick();
            chk($sformatf("vec%0d_lat2", i), 32'(io.out_valid), 0);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(io.out_valid), 1);
            chk($sformatf("vec%0d_data", i), 32'(io.out_data),
                32'(vecs[i].exp));
            chk($sformatf("vec%0d_model", i), 32'(io.out_data),
                32'(model(vecs[i].op, vecs[i].a, vecs[i].b)));
            chk($sformatf("vec%0d_tag", i), 32'(io.out_tag),
                32'(vecs[i].tag));
            tick();
        end

        // backpressure: three held, fourth refused, then drained in order
        io.out_ready = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            io.in_valid = 1'b1;
            io.in_op = 2'b00;
            io.in_a = 16'(t);
            io.in_b = 16'h0003;
            io.in_tag = 3'(t);
            chk($sformatf("bp_ready%0d", t), 32'(io.in_ready),
                (t < 4) ? 1 : 0);
            if (t < 4) tick();
        end
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_valid", 32'(io.out_valid), 1);
            chk("bp_hold_tag", 32'(io.out_tag), 1);
            chk("bp_hold_data", 32'(io.out_data), 3);
            chk("bp_hold_ready", 32'(io.in_ready), 0);
            tick();
        end
        io.out_ready = 1'b1;
        #1;
        chk("bp_ready4_after", 32'(io.in_ready), 1);
        for (int t = 1; t <= 4; t++) begin
            chk($sformatf("bp_out_valid%0d", t), 32'(io.out_valid), 1);
            chk($sformatf("bp_out_tag%0d", t), 32'(io.out_tag), 32'(t));
            chk($sformatf("bp_out_data%0d", t), 32'(io.out_data),
                32'(3 * t));
            tick();
            idle();
        end
        chk("bp_empty", 32'(io.busy), 0);

        // flush with three ops in flight
        for (int t = 1; t <= 3; t++) begin
            io.in_valid = 1'b1;
            io.in_op = 2'b11;
            io.in_a = 16'hF000;
            io.in_b = 16'(t);
            io.in_tag = 3'(t);
            tick();
        end
        io.flush = 1'b1;
        #1;
        chk("fl_in_ready", 32'(io.in_ready), 0);
        chk("fl_busy_before", 32'(io.busy), 1);
        tick();
        io.flush = 1'b0;
        idle();
        chk("fl_out_valid", 32'(io.out_valid), 0);
        chk("fl_busy", 32'(io.busy), 0);
        io.in_valid = 1'b1;
        io.in_op = 2'b01;
        io.in_a = 16'hFFFD;
        io.in_b = 16'h7000;
        io.in_tag = 3'd6;
        tick();
        idle();
        tick();
        tick();
        chk("fl_new_valid", 32'(io.out_valid), 1);
        chk("fl_new_data", 32'(io.out_data),
            32'(model(2'b01, 16'hFFFD, 16'h7000)));
        chk("fl_new_tag", 32'(io.out_tag), 6);
        tick();

        // asynchronous reset with ops in flight
        for (int t = 1; t <= 2; t++) begin
            io.in_valid = 1'b1;
            io.in_op = 2'b00;
            io.in_a = 16'h0101;
            io.in_b = 16'(t + 1);
            io.in_tag = 3'(t);
            tick();
        end
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(io.out_valid), 0);
        chk("ar_busy", 32'(io.busy), 0);
        chk("ar_out_data", 32'(io.out_data), 0);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("ar_no_stale", 32'(io.out_valid), 0);
        end

        // random traffic against the scoreboard
        held = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            io.in_valid = ($urandom_range(0, 3) != 0);
            io.in_op = 2'($urandom);
            io.in_a = 16'($urandom);
            io.in_b = 16'($urandom);
            io.in_tag = 3'($urandom);
            io.out_ready = ($urandom_range(0, 2) != 0);
            io.flush = ($urandom_range(0, 49) == 0);
            #1;
            if (held) begin
                chk("rnd_stable_data", 32'(io.out_data), 32'(held_d));
                chk("rnd_stable_tag", 32'(io.out_tag), 32'(held_t));
            end
            if (io.flush) chk("rnd_flush_ready", 32'(io.in_ready), 0);
            if (io.out_valid) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected", 32'(io.out_valid), 0);
                end else if (io.out_ready) begin
                    chk("rnd_data", 32'(io.out_data), 32'(q[0].d));
                    chk("rnd_tag", 32'(io.out_tag), 32'(q[0].t));
                    void'(q.pop_front());
                end
            end
            held = io.out_valid && !io.out_ready && !io.flush;
            held_d = io.out_data;
            held_t = io.out_tag;
            if (io.flush) q.delete();
            else if (io.in_valid && io.in_ready)
                q.push_back('{model(io.in_op, io.in_a, io.in_b),
                              io.in_tag});
            if (q.size() > 3) chk("rnd_capacity", 32'(q.size()), 3);
            tick();
        end
        io.flush = 1'b0;
        idle();
        io.out_ready = 1'b1;
        for (int c = 0; c < 50 && q.size() > 0; c++) begin
            #1;
            if (io.out_valid) begin
                chk("drain_data", 32'(io.out_data), 32'(q[0].d));
                chk("drain_tag", 32'(io.out_tag), 32'(q[0].t));
                void'(q.pop_front());
            end
            tick();
        end
        chk("drain_left", 32'(q.size()), 0);
        #1;
        chk("drain_busy", 32'(io.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul_exec_stage.md
Name: mul_exec_stage

Overview:
- Pipelined execute stage wrapping the team's existing unsigned NxN combinational MUL array multiplier.
- Accepts multiply micro-ops from decode/issue over a valid/ready handshake and applies sign correction for the signed variants.
- Registers the 2N-bit product, selects the low or high half, and hands a tagged N-bit result to register-file writeback over valid/ready.
- Supports pipeline flush (branch redirect) and full backpressure without loss or reordering.

Parameters:
- N, 16, operand and result width.
- TAG_W, 3, width of the destination-register tag carried alongside each op.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  issue presents an op
- in_ready  output  1  stage accepts the op this cycle
- in_op  input  2  00 MUL (low half), 01 MULH (s x s, high), 10 MULHSU (s x u, high), 11 MULHU (u x u, high)
- in_a  input  N  rs1 operand
- in_b  input  N  rs2 operand
- in_tag  input  TAG_W  destination tag
- flush  input  1  synchronous kill of all in-flight ops
- out_valid  output  1  result available
- out_ready  input  1  writeback consumes the result
- out_data  output  N  selected result half
- out_tag  output  TAG_W  tag of the result
- busy  output  1  any stage holds a valid op

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: all stage valid bits 0, so out_valid=0 and busy=0. out_data=0 and out_tag=0. The internal data registers are cleared to 0.
- Pipeline structure: three register stages, S1 to S3, each with its own valid bit. An input handshake is in_valid && in_ready. The output handshake is out_valid && out_ready.
- S1 (operand condition):
  - Captures op, tag and the operand magnitudes, plus neg = predicted result sign.
  - MULH: |a|, |b|, neg = a[N-1]^b[N-1].
  - MULHSU: |a|, b, neg = a[N-1].
  - MULHU and MUL: a, b, neg = 0. The low half is sign-independent.
  - Magnitude is unsigned N bits, so |0x8000| = 0x8000 with no overflow.
- S2 (product): registers the 2N-bit unsigned product of the S1 magnitudes from the MUL core, together with op, tag and neg.
- S3 (result): applies 2N-bit two's-complement negation when neg=1, then selects bits [N-1:0] for MUL and [2N-1:N] otherwise. S3 drives out_data and out_tag directly from registers.
- Latency: exactly 3 cycles from the input handshake to out_valid, with no stall. Throughput is 1 op/cycle.
- Flow control (bubble-collapsing):
  - Stage k loads when it is empty or its contents move forward in the same cycle.
  - S3 moves on the output handshake.
  - in_ready = !flush && (!S1.valid || S1 moves). This is combinational from out_ready through the valid bits.
- Backpressure: with out_ready=0, up to 3 ops are held (S1 to S3 full). in_ready then falls to 0. Register contents hold stable, and out_data and out_tag do not change while out_valid=1 and out_ready=0.
- Ordering: results leave strictly in acceptance order. Ops are never dropped or duplicated.
- Flush:
  - When flush=1 at a clock edge, all stage valid bits clear at that edge.
  - in_ready=0 during flush, so no op is accepted in that cycle.
  - An output handshake in the flush cycle still counts as consumed (out_valid was 1 and out_ready 1 before the edge).
  - out_valid=0 from the next cycle.
- busy = S1.valid | S2.valid | S3.valid.
- Reset mid-operation: assertion clears all valid bits immediately (asynchronous). No partial result is emitted after deassertion.
- Arithmetic: internal product and negation are 2N bits wide. There is no saturation. Results wrap modulo 2^N per half-selection.

Test Plan:
- Basic timing: MUL a=0x1234 b=0x0010, out_ready=1 -> out_valid exactly 3 cycles after handshake, out_data=0x2340, out_tag equals the issued tag.
- Signed high: MULH a=0x8000 b=0x8000 -> 0x4000. MULH a=0xFFFF b=0x0002 -> 0xFFFF (product -2).
- Mixed and unsigned high: MULHU a=0xFFFF b=0xFFFF -> 0xFFFE. MULHSU a=0xFFFF b=0xFFFF -> 0xFFFF (product 0xFFFF0001). MUL a=0xFFFF b=0xFFFF -> 0x0001.
- Backpressure: out_ready=0, issue tags 1,2,3,4 back-to-back -> ops 1-3 accepted, in_ready=0 on op 4, out_data stable. Raise out_ready -> tags 1,2,3,4 emerge in order, one per cycle, no loss.
- Flush: 3 ops in flight with out_ready=1, assert flush 1 cycle -> out_valid=0 and busy=0 next cycle, in_ready=0 during flush. A new op issued after flush returns a correct result 3 cycles later.
- Reset mid-flight: 2 ops in flight, pulse rst_n low between clock edges -> out_valid=0, busy=0, out_data=0 immediately. No stale result appears after release.
